// File: rtl/ibex_lsm_seed_bank.sv
// Bank of Galois-LFSR mask seed channels for secure load/store datapaths.
// CSR-visible per-channel state, one registered mask per cycle, usage-based reseed requests.
module ibex_lsm_seed_bank #(
   parameter int                   NSeeds       = 4,
   parameter int                   SeedWidth    = 32,
   parameter logic [SeedWidth-1:0] Poly         = 32'h80200003,
   parameter logic [11:0]          CsrBase      = 12'h800,
   parameter int                   ReseedThresh = 1024,
   localparam int                  ChanW        = (NSeeds > 1) ? $clog2(NSeeds) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [11:0]          csr_addr_i,
   input  logic                 csr_we_i,
   input  logic [SeedWidth-1:0] csr_wdata_i,
   output logic                 csr_hit_o,
   output logic [SeedWidth-1:0] csr_rdata_o,
   input  logic                 mask_req_i,
   input  logic [ChanW-1:0]     mask_chan_i,
   output logic                 mask_valid_o,
   output logic [SeedWidth-1:0] mask_o,
   output logic                 mask_err_o,
   output logic [NSeeds-1:0]    reseed_req_o
);

   localparam int                CntW      = $clog2(ReseedThresh + 1);
   localparam logic [CntW-1:0]   THRESH_C  = CntW'(ReseedThresh);
   localparam logic [CntW-1:0]   ONE_C     = CntW'(1);
   localparam logic [11:0]       NSEEDS_A  = 12'(NSeeds);
   localparam logic [ChanW:0]    NSEEDS_C  = (ChanW + 1)'(NSeeds);

   logic [1:0]           rst_sync_q;
   logic                 rst_int;
   logic [SeedWidth-1:0] state_q [NSeeds];
   logic [CntW-1:0]      left_q  [NSeeds];
   logic [11:0]          csr_off;
   logic                 chan_ok;
   logic [SeedWidth-1:0] mask_sel;

   function automatic logic [SeedWidth-1:0] lfsr_step(input logic [SeedWidth-1:0] s);
      return s[0] ? ((s >> 1) ^ Poly) : (s >> 1);
   endfunction

   // Assertion reaches every flop immediately; release is aligned to clk_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rst_sync_q <= 2'b11;
      else       rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_int = rst_sync_q[1];

   assign csr_off   = csr_addr_i - CsrBase;
   assign csr_hit_o = (csr_off < NSEEDS_A);
   assign chan_ok   = ({1'b0, mask_chan_i} < NSEEDS_C);

   always_comb begin
      csr_rdata_o = '0;
      mask_sel    = '0;
      for (int i = 0; i < NSeeds; i++) begin
         if (csr_hit_o && csr_off == 12'(i))           csr_rdata_o = state_q[i];
         if (chan_ok && {1'b0, mask_chan_i} == (ChanW + 1)'(i)) mask_sel = state_q[i];
      end
   end

   // left_q counts down the masks remaining before a reseed is requested.
   always_ff @(posedge clk_i or posedge rst_int) begin
      if (rst_int) begin
         for (int i = 0; i < NSeeds; i++) begin
            state_q[i] <= SeedWidth'(1);
            left_q[i]  <= THRESH_C;
         end
         reseed_req_o <= '0;
      end else begin
         for (int i = 0; i < NSeeds; i++) begin
            if (csr_we_i && csr_hit_o && csr_off == 12'(i)) begin
               state_q[i]      <= (csr_wdata_i == '0) ? SeedWidth'(1) : csr_wdata_i;
               left_q[i]       <= THRESH_C;
               reseed_req_o[i] <= 1'b0;
            end else if (mask_req_i && chan_ok && {1'b0, mask_chan_i} == (ChanW + 1)'(i)) begin
               state_q[i] <= lfsr_step(state_q[i]);
               if (left_q[i] != '0) begin
                  left_q[i] <= left_q[i] - ONE_C;
                  if (left_q[i] == ONE_C) reseed_req_o[i] <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_int) begin
      if (rst_int) begin
         mask_valid_o <= 1'b0;
         mask_o       <= '0;
         mask_err_o   <= 1'b0;
      end else begin
         mask_valid_o <= mask_req_i;
         mask_err_o   <= mask_req_i && !chan_ok;
         if (mask_req_i) mask_o <= chan_ok ? mask_sel : '0;
      end
   end

endmodule

// File: tb/tb_ibex_lsm_seed_bank.sv
// Directed bench for ibex_lsm_seed_bank: a four-channel bank with a short reseed
// threshold and a three-channel bank for out-of-range channel handling.
module tb_ibex_lsm_seed_bank;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [11:0] csr_addr_i = 12'h000;
   logic        csr_we_i = 1'b0;
   logic [31:0] csr_wdata_i = '0;
   logic        mask_req_i = 1'b0;
   logic [1:0]  mask_chan_i = '0;

   logic        csr_hit_o;
   logic [31:0] csr_rdata_o;
   logic        mask_valid_o;
   logic [31:0] mask_o;
   logic        mask_err_o;
   logic [3:0]  reseed_req_o;

   logic        b_hit;
   logic [31:0] b_rdata;
   logic        b_valid;
   logic [31:0] b_mask;
   logic        b_err;
   logic [2:0]  b_reseed;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   ibex_lsm_seed_bank #(.NSeeds(4), .ReseedThresh(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i),
      .csr_hit_o(csr_hit_o), .csr_rdata_o(csr_rdata_o),
      .mask_req_i(mask_req_i), .mask_chan_i(mask_chan_i),
      .mask_valid_o(mask_valid_o), .mask_o(mask_o), .mask_err_o(mask_err_o),
      .reseed_req_o(reseed_req_o)
   );

   ibex_lsm_seed_bank #(.NSeeds(3)) dut3 (
      .clk_i(clk_i), .rst_i(rst_i),
      .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i),
      .csr_hit_o(b_hit), .csr_rdata_o(b_rdata),
      .mask_req_i(mask_req_i), .mask_chan_i(mask_chan_i),
      .mask_valid_o(b_valid), .mask_o(b_mask), .mask_err_o(b_err),
      .reseed_req_o(b_reseed)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      mask_req_i = 1'b0;
      csr_we_i   = 1'b0;
      rst_i      = 1'b1;
      tick();
      rst_i = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (mask_valid_o !== 1'b0 || mask_o !== 32'h0 || mask_err_o !== 1'b0 || reseed_req_o !== 4'b0) begin
         bad++;
         $display("FAIL reset_outputs: valid=%b mask=%h err=%b reseed=%b, want 0/0/0/0",
                  mask_valid_o, mask_o, mask_err_o, reseed_req_o);
      end
      csr_addr_i = 12'h803;
      #1;
      total++;
      if (csr_hit_o !== 1'b1 || csr_rdata_o !== 32'h1) begin
         bad++;
         $display("FAIL reset_state: hit=%b rdata=%h, want 1/00000001", csr_hit_o, csr_rdata_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [3];
      exp[0] = 32'h00000001; exp[1] = 32'h80200003; exp[2] = 32'hC0300002;
      do_reset();
      mask_req_i  = 1'b1;
      mask_chan_i = 2'd0;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (mask_valid_o !== 1'b1 || mask_o !== exp[k] || mask_err_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_mask%0d: valid=%b mask=%h err=%b, want 1/%h/0",
                     k, mask_valid_o, mask_o, mask_err_o, exp[k]);
         end
      end
      mask_req_i = 1'b0;
      tick();
      total++;
      if (mask_valid_o !== 1'b0 || mask_o !== 32'hC0300002) begin
         bad++;
         $display("FAIL idle_hold: valid=%b mask=%h, want 0/c0300002", mask_valid_o, mask_o);
      end
      csr_addr_i = 12'h800;
      #1;
      total++;
      if (csr_rdata_o !== 32'h60180001) begin
         bad++;
         $display("FAIL step_read: rdata=%h, want 60180001", csr_rdata_o);
      end
   endtask

   task automatic test_csr();
      do_reset();
      csr_addr_i = 12'h802; csr_wdata_i = 32'hDEADBEEF; csr_we_i = 1'b1;
      tick();
      csr_we_i = 1'b0;
      #1;
      total++;
      if (csr_hit_o !== 1'b1 || csr_rdata_o !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL csr_write: hit=%b rdata=%h, want 1/deadbeef", csr_hit_o, csr_rdata_o);
      end
      csr_addr_i = 12'h804;
      #1;
      total++;
      if (csr_hit_o !== 1'b0 || csr_rdata_o !== 32'h0) begin
         bad++;
         $display("FAIL csr_miss_hi: hit=%b rdata=%h, want 0/0", csr_hit_o, csr_rdata_o);
      end
      csr_addr_i = 12'h7FF;
      #1;
      total++;
      if (csr_hit_o !== 1'b0 || csr_rdata_o !== 32'h0) begin
         bad++;
         $display("FAIL csr_miss_lo: hit=%b rdata=%h, want 0/0", csr_hit_o, csr_rdata_o);
      end
      csr_addr_i = 12'h801; csr_wdata_i = 32'hCAFEF00D; csr_we_i = 1'b1;
      tick();
      csr_wdata_i = 32'h0;
      tick();
      csr_we_i = 1'b0;
      #1;
      total++;
      if (csr_rdata_o !== 32'h00000001) begin
         bad++;
         $display("FAIL zero_write: rdata=%h, want 00000001", csr_rdata_o);
      end
      // A write that misses must leave every channel untouched.
      csr_addr_i = 12'h804; csr_wdata_i = 32'h55555555; csr_we_i = 1'b1;
      tick();
      csr_we_i = 1'b0;
      csr_addr_i = 12'h803;
      #1;
      total++;
      if (csr_rdata_o !== 32'h1) begin
         bad++;
         $display("FAIL miss_write: ch3 rdata=%h, want 00000001", csr_rdata_o);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      csr_addr_i = 12'h800; csr_wdata_i = 32'h12345678; csr_we_i = 1'b1;
      mask_req_i = 1'b1; mask_chan_i = 2'd0;
      tick();
      csr_we_i = 1'b0;
      total++;
      if (mask_valid_o !== 1'b1 || mask_o !== 32'h00000001) begin
         bad++;
         $display("FAIL same_pre_write: valid=%b mask=%h, want 1/00000001", mask_valid_o, mask_o);
      end
      tick();
      mask_req_i = 1'b0;
      total++;
      if (mask_valid_o !== 1'b1 || mask_o !== 32'h12345678) begin
         bad++;
         $display("FAIL same_written: valid=%b mask=%h, want 1/12345678", mask_valid_o, mask_o);
      end
      // Write ch3 while ch0 issues: independent channels.
      csr_addr_i = 12'h803; csr_wdata_i = 32'hA5A5A5A5; csr_we_i = 1'b1;
      mask_req_i = 1'b1; mask_chan_i = 2'd0;
      tick();
      csr_we_i = 1'b0; mask_req_i = 1'b0;
      total++;
      if (mask_o !== 32'h091A2B3C || csr_rdata_o !== 32'hA5A5A5A5) begin
         bad++;
         $display("FAIL diff_chan: mask=%h ch3=%h, want 091a2b3c/a5a5a5a5", mask_o, csr_rdata_o);
      end
   endtask

   task automatic test_reseed();
      logic [31:0] exp [5];
      exp[0] = 32'h00000001; exp[1] = 32'h80200003; exp[2] = 32'hC0300002;
      exp[3] = 32'h60180001; exp[4] = 32'hB02C0003;
      do_reset();
      mask_req_i = 1'b1; mask_chan_i = 2'd1;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if (mask_valid_o !== 1'b1 || mask_o !== exp[k] ||
             reseed_req_o !== ((k >= 3) ? 4'b0010 : 4'b0000)) begin
            bad++;
            $display("FAIL reseed_req%0d: valid=%b mask=%h reseed=%b, want 1/%h/%b",
                     k, mask_valid_o, mask_o, reseed_req_o, exp[k],
                     (k >= 3) ? 4'b0010 : 4'b0000);
         end
      end
      mask_req_i = 1'b0;
      csr_addr_i = 12'h801;
      #1;
      total++;
      if (csr_rdata_o !== 32'hD8360002) begin
         bad++;
         $display("FAIL reseed_state: rdata=%h, want d8360002", csr_rdata_o);
      end
      csr_wdata_i = 32'h0BADCAFE; csr_we_i = 1'b1;
      tick();
      csr_we_i = 1'b0;
      total++;
      if (reseed_req_o !== 4'b0000) begin
         bad++;
         $display("FAIL reseed_clear: reseed=%b, want 0000", reseed_req_o);
      end
      // Count restarts after the write: three more masks must not re-raise it.
      mask_req_i = 1'b1;
      repeat (3) tick();
      mask_req_i = 1'b0;
      total++;
      if (reseed_req_o !== 4'b0000) begin
         bad++;
         $display("FAIL reseed_restart: reseed=%b, want 0000", reseed_req_o);
      end
   endtask

   task automatic test_out_of_range();
      do_reset();
      mask_req_i = 1'b1; mask_chan_i = 2'd3;
      tick();
      mask_req_i = 1'b0;
      total++;
      if (b_valid !== 1'b1 || b_err !== 1'b1 || b_mask !== 32'h0 || b_reseed !== 3'b000) begin
         bad++;
         $display("FAIL oor_resp: valid=%b err=%b mask=%h reseed=%b, want 1/1/0/000",
                  b_valid, b_err, b_mask, b_reseed);
      end
      for (int c = 0; c < 3; c++) begin
         csr_addr_i = 12'h800 + 12'(c);
         #1;
         total++;
         if (b_hit !== 1'b1 || b_rdata !== 32'h1) begin
            bad++;
            $display("FAIL oor_state%0d: hit=%b rdata=%h, want 1/00000001", c, b_hit, b_rdata);
         end
      end
      csr_addr_i = 12'h803;
      #1;
      total++;
      if (b_hit !== 1'b0 || b_rdata !== 32'h0) begin
         bad++;
         $display("FAIL oor_csr_miss: hit=%b rdata=%h, want 0/0", b_hit, b_rdata);
      end
      mask_req_i = 1'b1; mask_chan_i = 2'd2;
      tick();
      mask_req_i = 1'b0;
      total++;
      if (b_valid !== 1'b1 || b_err !== 1'b0 || b_mask !== 32'h1) begin
         bad++;
         $display("FAIL inrange_resp: valid=%b err=%b mask=%h, want 1/0/00000001",
                  b_valid, b_err, b_mask);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      csr_addr_i = 12'h802; csr_wdata_i = 32'hDEADBEEF; csr_we_i = 1'b1;
      tick();
      csr_we_i = 1'b0;
      mask_req_i = 1'b1; mask_chan_i = 2'd2;
      tick();
      total++;
      if (mask_valid_o !== 1'b1 || mask_o !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL pre_reset: valid=%b mask=%h, want 1/deadbeef", mask_valid_o, mask_o);
      end
      #2;
      rst_i = 1'b1;
      #1;
      total++;
      if (mask_valid_o !== 1'b0 || mask_o !== 32'h0) begin
         bad++;
         $display("FAIL async_reset: valid=%b mask=%h, want 0/0", mask_valid_o, mask_o);
      end
      mask_req_i = 1'b0;
      tick();
      rst_i = 1'b0;
      repeat (3) tick();
      csr_addr_i = 12'h802;
      #1;
      total++;
      if (csr_rdata_o !== 32'h1 || mask_valid_o !== 1'b0) begin
         bad++;
         $display("FAIL post_reset: ch2=%h valid=%b, want 00000001/0", csr_rdata_o, mask_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_csr();
      test_same_cycle();
      test_reseed();
      test_out_of_range();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
